// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_in_capture
//  Purpose  : GPIO input path: pin synchroniser, per-pin debounce, rise/fall
//             edge detection and latched per-pin interrupt pending bits.
//  Revision : 1.0  initial release
// ============================================================================
module gpio_in_capture #(
  parameter int GPIO_WIDTH     = 13,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [GPIO_WIDTH-1:0]     gpio_in,
  input  logic [GPIO_WIDTH-1:0]     select,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles,
  input  logic [GPIO_WIDTH-1:0]     rise_en,
  input  logic [GPIO_WIDTH-1:0]     fall_en,
  input  logic [GPIO_WIDTH-1:0]     irq_clear,
  output logic [GPIO_WIDTH-1:0]     pin_state,
  output logic [GPIO_WIDTH-1:0]     periph_in,
  output logic [GPIO_WIDTH-1:0]     irq_pending,
  output logic                      irq
);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_t;

  localparam int c_prime_len = SYNC_STAGES + 1;
  localparam int c_prime_w   = $clog2(c_prime_len + 1);
  localparam logic [c_prime_w-1:0]      c_prime_last = c_prime_w'(c_prime_len);
  localparam logic [c_prime_w-1:0]      c_prime_one  = c_prime_w'(1);
  localparam logic [DEBOUNCE_WIDTH-1:0] c_cnt_one    = DEBOUNCE_WIDTH'(1);
  localparam logic [DEBOUNCE_WIDTH:0]   c_inc_one    = (DEBOUNCE_WIDTH + 1)'(1);

  logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] w_s;
  logic [c_prime_w-1:0]  r_prime_cnt;
  logic                  w_priming;
  logic                  w_n_le1;
  logic                  r_irq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign periph_in = w_s & select;

  // Prime window: pin_state tracks the synchroniser so boot-time levels
  // never look like edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        r_prime_cnt <= '0;
    else if (w_priming) r_prime_cnt <= r_prime_cnt + c_prime_one;
  end

  assign w_priming = (r_prime_cnt != c_prime_last);
  assign w_n_le1   = (debounce_cycles <= c_cnt_one);

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    deb_state_t                r_state, w_state_nxt;
    logic [DEBOUNCE_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DEBOUNCE_WIDTH:0]   w_cnt_inc;
    logic                      r_pin, w_pin_nxt;
    logic                      r_prev;
    logic                      r_pend;
    logic                      w_event;

    assign w_cnt_inc = {1'b0, r_cnt} + c_inc_one;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_pin   <= 1'b0;
        r_prev  <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pin   <= w_pin_nxt;
        // prev is primed alongside pin_state so the first post-prime cycle
        // sees no difference between them.
        r_prev  <= w_priming ? w_s[i] : r_pin;
        r_pend  <= w_event | (r_pend & ~irq_clear[i]);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pin_nxt   = r_pin;
      if (w_priming) begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
        w_pin_nxt   = w_s[i];
      end else begin
        case (r_state)
          ST_STABLE: begin
            w_cnt_nxt = '0;
            if (w_s[i] != r_pin) begin
              if (w_n_le1) begin
                w_pin_nxt = w_s[i];
              end else begin
                w_cnt_nxt   = c_cnt_one;
                w_state_nxt = ST_COUNTING;
              end
            end
          end
          ST_COUNTING: begin
            if (w_s[i] == r_pin) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_STABLE;
            end else if (w_cnt_inc >= {1'b0, debounce_cycles}) begin
              // Threshold is compared live, so lowering N mid-count acts now.
              w_pin_nxt   = w_s[i];
              w_cnt_nxt   = '0;
              w_state_nxt = ST_STABLE;
            end else if (r_cnt != '1) begin
              w_cnt_nxt = w_cnt_inc[DEBOUNCE_WIDTH-1:0];
            end
          end
          default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
          end
        endcase
      end
    end

    assign w_event = ((r_pin & ~r_prev & rise_en[i]) | (~r_pin & r_prev & fall_en[i]))
                     & ~select[i] & ~w_priming;

    assign pin_state[i]   = r_pin;
    assign irq_pending[i] = r_pend;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= |irq_pending;
  end

  assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_in_capture
//  Purpose  : Directed vector table plus multi-cycle sequences for the GPIO
//             input capture block.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpio_in_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic [12:0] gpio_in, select, rise_en, fall_en, irq_clear;
  logic [15:0] debounce_cycles;
  logic [12:0] pin_state, periph_in, irq_pending;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [12:0] gpio, sel, rise, fall, clr;
    logic [15:0] n;
    logic [12:0] e_pin, e_periph, e_pend;
    logic        e_irq;
  } vec_t;

  vec_t tbl [0:31];
  int   nv = 0;

  gpio_in_capture #(
    .GPIO_WIDTH(13), .SYNC_STAGES(2), .DEBOUNCE_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .gpio_in(gpio_in), .select(select),
    .debounce_cycles(debounce_cycles), .rise_en(rise_en), .fall_en(fall_en),
    .irq_clear(irq_clear), .pin_state(pin_state), .periph_in(periph_in),
    .irq_pending(irq_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [12:0] g, s, r, f, c, input logic [15:0] n,
                         input logic [12:0] ep, epi, epe, input logic ei);
    tbl[nv] = '{gpio: g, sel: s, rise: r, fall: f, clr: c, n: n,
                e_pin: ep, e_periph: epi, e_pend: epe, e_irq: ei};
    nv++;
  endtask

  initial begin
    logic seen_glitch;

    // Pin 3 rise with N=0, then W1C clear
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h000, 16'd0, 13'h000, 13'h000, 13'h000, 1'b0);
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h000, 16'd0, 13'h000, 13'h000, 13'h000, 1'b0);
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h000, 16'd0, 13'h008, 13'h000, 13'h008, 1'b0);
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h000, 16'd0, 13'h008, 13'h000, 13'h008, 1'b1);
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h008, 16'd0, 13'h008, 13'h000, 13'h000, 1'b1);
    add_vec(13'h008, 13'h000, 13'h008, 13'h000, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    // Pin 7 owned by peripheral: periph_in follows, no events
    add_vec(13'h088, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    add_vec(13'h088, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h008, 13'h080, 13'h000, 1'b0);
    add_vec(13'h088, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h088, 13'h080, 13'h000, 1'b0);
    add_vec(13'h008, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h088, 13'h080, 13'h000, 1'b0);
    add_vec(13'h008, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h088, 13'h000, 13'h000, 1'b0);
    add_vec(13'h008, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    add_vec(13'h008, 13'h080, 13'h080, 13'h080, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    // Pin 7 handed back to GPIO: periph_in gated, rise event latches
    add_vec(13'h088, 13'h000, 13'h080, 13'h080, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    add_vec(13'h088, 13'h000, 13'h080, 13'h080, 13'h000, 16'd0, 13'h008, 13'h000, 13'h000, 1'b0);
    add_vec(13'h088, 13'h000, 13'h080, 13'h080, 13'h000, 16'd0, 13'h088, 13'h000, 13'h000, 1'b0);
    add_vec(13'h088, 13'h000, 13'h080, 13'h080, 13'h000, 16'd0, 13'h088, 13'h000, 13'h080, 1'b0);
    add_vec(13'h088, 13'h000, 13'h080, 13'h080, 13'h080, 16'd0, 13'h088, 13'h000, 13'h000, 1'b1);
    add_vec(13'h088, 13'h000, 13'h080, 13'h080, 13'h000, 16'd0, 13'h088, 13'h000, 13'h000, 1'b0);

    // Reset state with all pins high at boot
    resetn = 1'b0; gpio_in = 13'h1FFF; select = '0; rise_en = 13'h1FFF;
    fall_en = 13'h1FFF; irq_clear = '0; debounce_cycles = 16'd0;
    repeat (3) tick();
    chk("rst.pin", pin_state, 0);
    chk("rst.periph", periph_in, 0);
    chk("rst.pend", irq_pending, 0);
    chk("rst.irq", irq, 0);

    resetn = 1'b1;
    tick();
    tick();
    chk("prime.pin_early", pin_state, 13'h000);
    tick();
    chk("prime.pin", pin_state, 13'h1FFF);
    repeat (4) tick();
    chk("prime.pend", irq_pending, 0);
    chk("prime.irq", irq, 0);

    rise_en = '0; fall_en = '0; gpio_in = '0;
    repeat (5) tick();
    chk("idle.pin", pin_state, 0);
    chk("idle.pend", irq_pending, 0);

    for (int k = 0; k < nv; k++) begin
      gpio_in = tbl[k].gpio; select = tbl[k].sel; rise_en = tbl[k].rise;
      fall_en = tbl[k].fall; irq_clear = tbl[k].clr; debounce_cycles = tbl[k].n;
      tick();
      chk($sformatf("vec%0d.pin", k), pin_state, tbl[k].e_pin);
      chk($sformatf("vec%0d.periph", k), periph_in, tbl[k].e_periph);
      chk($sformatf("vec%0d.pend", k), irq_pending, tbl[k].e_pend);
      chk($sformatf("vec%0d.irq", k), irq, tbl[k].e_irq);
    end

    // Debounce N=10: 6-cycle glitch rejected, 10-cycle level accepted
    irq_clear = '0; select = '0; rise_en = '0; fall_en = '0; debounce_cycles = 16'd10;
    seen_glitch = 1'b0;
    gpio_in = 13'h0A8;
    for (int i = 0; i < 6; i++) begin tick(); if (pin_state[5]) seen_glitch = 1'b1; end
    gpio_in = 13'h088;
    for (int i = 0; i < 20; i++) begin tick(); if (pin_state[5]) seen_glitch = 1'b1; end
    chk("deb.glitch_seen", seen_glitch, 0);
    chk("deb.glitch_pin", pin_state, 13'h088);
    gpio_in = 13'h0A8;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 11) chk("deb.pin_at11", pin_state, 13'h088);
      if (i == 12) chk("deb.pin_at12", pin_state, 13'h0A8);
    end

    // Fall on pin 0 with clear in the same cycle: set wins
    debounce_cycles = 16'd0; gpio_in = 13'h0A9;
    repeat (5) tick();
    chk("sw.pin_hi", pin_state, 13'h0A9);
    fall_en = 13'h001; gpio_in = 13'h0A8;
    repeat (3) tick();
    chk("sw.pin_lo", pin_state, 13'h0A8);
    chk("sw.pend_before", irq_pending, 0);
    irq_clear = 13'h001;
    tick();
    chk("sw.pend_setwins", irq_pending, 13'h001);
    irq_clear = '0;
    tick();
    chk("sw.pend_held", irq_pending, 13'h001);
    chk("sw.irq", irq, 1);
    irq_clear = 13'h001;
    tick();
    chk("sw.pend_cleared", irq_pending, 0);
    irq_clear = '0;
    tick();
    chk("sw.irq_low", irq, 0);

    // N lowered mid-count from 100 to 20 at cnt=40
    fall_en = 13'h020; debounce_cycles = 16'd100; gpio_in = 13'h088;
    repeat (42) tick();
    chk("n.pin_counting", pin_state, 13'h0A8);
    debounce_cycles = 16'd20;
    tick();
    chk("n.pin_lowered", pin_state, 13'h088);
    tick();
    chk("n.pend", irq_pending, 13'h020);
    tick();
    chk("n.irq", irq, 1);

    // Async reset mid-count, then prime again
    select = 13'h1FFF; debounce_cycles = 16'd100; gpio_in = 13'h0A8;
    repeat (30) tick();
    chk("ar.pin_counting", pin_state, 13'h088);
    chk("ar.periph", periph_in, 13'h0A8);
    chk("ar.pend_kept", irq_pending, 13'h020);
    #2 resetn = 1'b0;
    #1;
    chk("ar.pin0", pin_state, 0);
    chk("ar.periph0", periph_in, 0);
    chk("ar.pend0", irq_pending, 0);
    chk("ar.irq0", irq, 0);
    tick();
    select = '0; rise_en = 13'h1FFF; fall_en = 13'h1FFF;
    resetn = 1'b1;
    tick();
    tick();
    chk("ar.prime_early", pin_state, 0);
    tick();
    chk("ar.prime_pin", pin_state, 13'h0A8);
    repeat (4) tick();
    chk("ar.prime_pend", irq_pending, 0);
    chk("ar.prime_irq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
